lc4_iter_divider: RTL
=====================

# lc4_iter_divider

Multi-cycle unsigned 16-bit divider for the LC4 datapath that sits directly downstream of the 16-bit carry-lookahead adder. It uses `cla16` instances as its subtractor: one restoring-division step per adder instance per clock. The ALU issues a start pulse with operands, waits on `o_busy`, then takes quotient and remainder when `o_done` pulses. It implements the LC4 `DIV`/`MOD` semantics, including the divide-by-zero convention (quotient 0, remainder 0).

## Interface
- `STEPS_PER_CYCLE`, default 1: quotient bits resolved per clock.
  - Legal values: 1, 2, 4.
  - Each step instantiates one `cla16`.
  - Iteration count N = 16 / `STEPS_PER_CYCLE`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_start` input 1: request a division; sampled only in IDLE or DONE.
- `i_dividend` input 16: unsigned dividend; sampled with `i_start`.
- `i_divisor` input 16: unsigned divisor; sampled with `i_start`.
- `o_busy` output 1: high while an operation is in progress (state RUN).
- `o_done` output 1: one-cycle pulse; results valid.
- `o_quotient` output 16: quotient; held until the next accepted start.
- `o_remainder` output 16: remainder; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `i_start`.
  - RUN → DONE after N iterations.
  - DONE → RUN on `i_start`; otherwise DONE → IDLE.
- Accepting a start:
  - Latch the divisor.
  - Load the quotient/shift register with the dividend.
  - Clear the partial remainder R (16 bits).
  - Set the iteration counter to N.
- One restoring step:
  - Form the 17-bit value T = {R, next dividend MSB}.
  - Subtract when T[16]=1 or T[15:0] >= divisor (unsigned compare).
  - On subtract: R = T[15:0] − divisor, computed by `cla16` with a=T[15:0], b=~divisor, cin=1 (the low 16 bits are exact mod 2^16); the quotient bit is 1.
  - Otherwise: R = T[15:0]; the quotient bit is 0.
- With `STEPS_PER_CYCLE` > 1, the steps chain combinationally within one cycle, MSB first.
- Divisor = 0: the final outputs are forced to quotient 0, remainder 0, regardless of the internal iteration result.
- `i_start` while in RUN is ignored; the operands are not sampled.
- Reset values: state IDLE; `o_busy`=0, `o_done`=0, `o_quotient`=0, `o_remainder`=0; counter 0.
- Reset mid-operation: abort immediately; all outputs take their reset values at that edge; no `o_done` is produced for the aborted operation.

## Timing
- Start accepted at edge E0 → `o_busy`=1 from E0.
- Iterations complete at edges E1..EN.
- At edge EN:
  - state becomes DONE;
  - `o_done`=1 for exactly one cycle;
  - `o_busy`=0;
  - `o_quotient`/`o_remainder` update.
- Latency from the accepting edge to `o_done` is N cycles (16, 8 or 4).
- Back-to-back operation: a start sampled in the DONE cycle is accepted at that edge.
  - The previous results stay visible during that DONE cycle.
  - The outputs keep their values until the new operation's EN.
- `rst` wins over `i_start` at the same edge.
- The critical path is `STEPS_PER_CYCLE` chained `cla16` + compare + mux stages.

## Configuration
- `LC4_DIV_ZERO_BYPASS_EN`
  - Defined: a start with divisor 0 goes to DONE at E1 (one-cycle latency) with quotient 0, remainder 0; no iterations run.
  - Undefined: divisor 0 runs the full N cycles; the outputs are still forced to 0/0 at EN.
- No other behaviour changes.

## Test plan
- 100 / 7, `STEPS_PER_CYCLE`=1 → `o_done` exactly 16 cycles after the accepting edge; quotient 14, remainder 2.
- 0xFFFF / 0x8000 and 0xFFFF / 1 → (1, 0x7FFF) and (0xFFFF, 0); exercises the T[16]=1 path. Repeat for each legal `STEPS_PER_CYCLE`, checking latency 16/8/4.
- 0x1234 / 0, with and without `LC4_DIV_ZERO_BYPASS_EN` → (0, 0); `o_done` after 1 cycle (bypass) or N cycles (no bypass).
- `i_start` with 50 / 3, then `i_start` pulsed with 9 / 9 during RUN → second request ignored; result (16, 2); exactly one `o_done`.
- Start 200 / 9, assert `rst` at iteration 5, then start 7 / 2 → no `o_done` for the aborted operation; outputs 0 after reset; second result (3, 1) with full latency.
- Back-to-back: 1000 / 10 with a new start (65535 / 256) in the DONE cycle → results (100, 0) then (255, 255); second `o_done` exactly N cycles later.

Source files
------------

// File: rtl/lc4_iter_divider.sv
// Multi-cycle unsigned 16/16 restoring divider built on cla16 subtractor stages.
// Optional macro LC4_DIV_ZERO_BYPASS_EN: divisor-0 requests finish one cycle after acceptance.

module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
    end

    // Group-level lookahead, fully expanded so no carry ripples between groups.
    always_comb begin
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    end

    always_comb begin
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c[4*j] = gc[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        c[16] = gc[4];
    end

    assign sum  = p ^ c[15:0];
    assign cout = c[16];
endmodule

// state  | meaning
// S_IDLE | waiting for i_start
// S_RUN  | iterating, STEPS_PER_CYCLE quotient bits per clock
// S_DONE | o_done pulse cycle; a new start may be accepted here
module lc4_iter_divider #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_dividend,
    input  logic [15:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_quotient,
    output logic [15:0] o_remainder
);
    localparam int        ITERS   = 16 / STEPS_PER_CYCLE;
    localparam logic [4:0] ITERS_L = 5'(ITERS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] divisor_q, divisor_d;
    logic [15:0] shreg_q, shreg_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] res_quo_q, res_quo_d;
    logic [15:0] res_rem_q, res_rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] r_ch  [0:STEPS_PER_CYCLE];
    logic [15:0] sh_ch [0:STEPS_PER_CYCLE];
    logic        div_zero;

    assign r_ch[0]  = rem_q;
    assign sh_ch[0] = shreg_q;
    assign div_zero = (divisor_q == 16'd0);

    for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
        logic [16:0] t;
        logic [15:0] diff;
        logic        no_borrow;
        logic        sub;

        assign t = {r_ch[k], sh_ch[k][15]};

        // Carry-out of T + ~D + 1 is exactly the unsigned T[15:0] >= D compare.
        cla16 u_sub (
            .a    (t[15:0]),
            .b    (~divisor_q),
            .cin  (1'b1),
            .sum  (diff),
            .cout (no_borrow)
        );

        assign sub        = t[16] | no_borrow;
        assign r_ch[k+1]  = sub ? diff : t[15:0];
        assign sh_ch[k+1] = {sh_ch[k][14:0], sub};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        shreg_d   = shreg_q;
        rem_d     = rem_q;
        res_quo_d = res_quo_q;
        res_rem_d = res_rem_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d   = S_RUN;
                    divisor_d = i_divisor;
                    shreg_d   = i_dividend;
                    rem_d     = 16'd0;
                    cnt_d     = ITERS_L;
`ifdef LC4_DIV_ZERO_BYPASS_EN
                    if (i_divisor == 16'd0) begin
                        cnt_d = 5'd1;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 5'd1;
`ifdef LC4_DIV_ZERO_BYPASS_EN
                if (!div_zero) begin
                    shreg_d = sh_ch[STEPS_PER_CYCLE];
                    rem_d   = r_ch[STEPS_PER_CYCLE];
                end
`else
                shreg_d = sh_ch[STEPS_PER_CYCLE];
                rem_d   = r_ch[STEPS_PER_CYCLE];
`endif
                if (cnt_q == 5'd1) begin
                    state_d   = S_DONE;
                    res_quo_d = div_zero ? 16'd0 : sh_ch[STEPS_PER_CYCLE];
                    res_rem_d = div_zero ? 16'd0 : r_ch[STEPS_PER_CYCLE];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_q == S_RUN) && (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            divisor_q <= 16'd0;
            shreg_q   <= 16'd0;
            rem_q     <= 16'd0;
            res_quo_q <= 16'd0;
            res_rem_q <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            shreg_q   <= shreg_d;
            rem_q     <= rem_d;
            res_quo_q <= res_quo_d;
            res_rem_q <= res_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_quotient  = res_quo_q;
    assign o_remainder = res_rem_q;
endmodule
